// File: rtl/button_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : button_pulse_gen
// Brief    : Synchronises and debounces a raw push-button, emitting one enable
//            pulse per press plus optional auto-repeat pulses while held.
// Revision : 1.0 - initial release
// ============================================================================
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse_out,
    output logic btn_level,
    output logic repeat_active
);

    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST     = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);
    localparam logic               c_REPEAT_EN   = (REPEAT_DELAY > 0);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic [c_DB_W-1:0]  w_db_cnt_nxt;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic [c_REP_W-1:0] w_rep_cnt_nxt;
    logic               w_pulse_nxt;
    logic               w_level_nxt;
    logic               w_rep_active_nxt;

    // btn_in is asynchronous; only r_sync2 is safe to use downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_db_cnt      <= '0;
            r_rep_cnt     <= '0;
            pulse_out     <= 1'b0;
            btn_level     <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_db_cnt      <= w_db_cnt_nxt;
            r_rep_cnt     <= w_rep_cnt_nxt;
            pulse_out     <= w_pulse_nxt;
            btn_level     <= w_level_nxt;
            repeat_active <= w_rep_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_db_cnt_nxt     = r_db_cnt;
        w_rep_cnt_nxt    = r_rep_cnt;
        w_pulse_nxt      = 1'b0;
        w_level_nxt      = btn_level;
        w_rep_active_nxt = repeat_active;

        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt  = DB_PRESS;
                    w_db_cnt_nxt = '0;
                end
            end

            DB_PRESS: begin
                if (!r_sync2) begin
                    w_state_nxt  = IDLE;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt      = PRESSED;
                    w_db_cnt_nxt     = '0;
                    w_rep_cnt_nxt    = '0;
                    w_level_nxt      = 1'b1;
                    w_pulse_nxt      = 1'b1;
                    w_rep_active_nxt = 1'b0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end

            PRESSED: begin
                if (!r_sync2) begin
                    w_state_nxt      = DB_RELEASE;
                    w_db_cnt_nxt     = '0;
                    w_rep_cnt_nxt    = '0;
                    w_rep_active_nxt = 1'b0;
                end else if (c_REPEAT_EN) begin
                    // First repeat waits the long delay, later ones the short period.
                    if (!repeat_active && (r_rep_cnt == c_DELAY_LAST)) begin
                        w_pulse_nxt      = 1'b1;
                        w_rep_active_nxt = 1'b1;
                        w_rep_cnt_nxt    = '0;
                    end else if (repeat_active && (r_rep_cnt == c_PERIOD_LAST)) begin
                        w_pulse_nxt   = 1'b1;
                        w_rep_cnt_nxt = '0;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                    end
                end
            end

            DB_RELEASE: begin
                if (r_sync2) begin
                    // Release bounce: resume holding, repeat timing restarts.
                    w_state_nxt      = PRESSED;
                    w_db_cnt_nxt     = '0;
                    w_rep_cnt_nxt    = '0;
                    w_rep_active_nxt = 1'b0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt  = IDLE;
                    w_db_cnt_nxt = '0;
                    w_level_nxt  = 1'b0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
